// File: rtl/pe_tile_ctrl_pkg.sv
// rtl/pe_tile_ctrl_pkg.sv - shared constants, phase enum and count derivation for the PE tile sequencer
package pe_tile_ctrl_pkg;

  localparam int GLB_ADDR_W  = 16;
  localparam int DATA_BITS   = 32;
  localparam int CONFIG_SIZE = 13;

  localparam int CFG_DW_BIT   = 12;
  localparam int CFG_RS_LSB   = 10;
  localparam int CFG_MODE_BIT = 9;
  localparam int CFG_P_LSB    = 7;
  localparam int CFG_F_LSB    = 2;
  localparam int CFG_Q_LSB    = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_FILT,
    ST_IFM,
    ST_IPS,
    ST_OPS,
    ST_DONE
  } phase_e;

  typedef struct packed {
    logic [4:0] nf;
    logic [2:0] np;
    logic [2:0] rs;
  } tile_counts_t;

  // cfg fields hold value-1; p*rs tops out at 16 so nf fits in 5 bits
  function automatic tile_counts_t derive_counts(input logic dw, input logic [1:0] rs_f,
                                                 input logic [1:0] p_f, input logic [1:0] q_f);
    tile_counts_t t;
    logic [2:0]   p;
    logic [2:0]   q;
    p    = {1'b0, p_f} + 3'd1;
    q    = {1'b0, q_f} + 3'd1;
    t.rs = {1'b0, rs_f} + 3'd1;
    t.nf = {2'b0, p} * {2'b0, t.rs};
    t.np = dw ? q : p;
    return t;
  endfunction

endpackage

// File: rtl/pe_tile_ctrl_if.sv
// rtl/pe_tile_ctrl_if.sv - GLB port and PE stream bundle between the tile sequencer and its environment
interface pe_tile_ctrl_if
  import pe_tile_ctrl_pkg::*;
#(
  parameter int ADDR_W = GLB_ADDR_W,
  parameter int DW     = DATA_BITS,
  parameter int CW     = CONFIG_SIZE
);
  logic              glb_en;
  logic              glb_we;
  logic [ADDR_W-1:0] glb_addr;
  logic [DW-1:0]     glb_wdata;
  logic [DW-1:0]     glb_rdata;

  logic              PE_en;
  logic [CW-1:0]     i_config;
  logic [DW-1:0]     filter;
  logic [DW-1:0]     ifmap;
  logic [DW-1:0]     ipsum;
  logic              filter_valid;
  logic              ifmap_valid;
  logic              ipsum_valid;
  logic              filter_ready;
  logic              ifmap_ready;
  logic              ipsum_ready;
  logic [DW-1:0]     opsum;
  logic              opsum_valid;
  logic              opsum_ready;

  modport master (
    output glb_en, glb_we, glb_addr, glb_wdata, PE_en, i_config,
           filter, ifmap, ipsum, filter_valid, ifmap_valid, ipsum_valid, opsum_ready,
    input  glb_rdata, filter_ready, ifmap_ready, ipsum_ready, opsum, opsum_valid
  );

  modport slave (
    input  glb_en, glb_we, glb_addr, glb_wdata, PE_en, i_config,
           filter, ifmap, ipsum, filter_valid, ifmap_valid, ipsum_valid, opsum_ready,
    output glb_rdata, filter_ready, ifmap_ready, ipsum_ready, opsum, opsum_valid
  );

endinterface

// File: rtl/pe_rd_stream.sv
// rtl/pe_rd_stream.sv - one-outstanding GLB read feeding a single-word holding register with valid/ready
module pe_rd_stream
  import pe_tile_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rd_avail_i,
  input  logic                 ready_i,
  input  logic [DATA_BITS-1:0] rdata_i,
  output logic                 rd_req_o,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  output logic                 xfer_o
);
  logic                 pend_q;
  logic                 full_q;
  logic [DATA_BITS-1:0] data_q;

  assign rd_req_o = rd_avail_i && !pend_q && !full_q;
  assign xfer_o   = full_q && ready_i;
  assign valid_o  = full_q;
  assign data_o   = data_q;

  // pend and full are mutually exclusive, so a new read waits until the word has left
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      pend_q <= rd_req_o;
      if (pend_q) begin
        data_q <= rdata_i;
        full_q <= 1'b1;
      end else if (xfer_o) begin
        full_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pe_tile_ctrl.sv
// rtl/pe_tile_ctrl.sv - sequences one PE through a tile: config, filter/ifmap/ipsum streaming, opsum write-back
module pe_tile_ctrl
  import pe_tile_ctrl_pkg::*;
#(
  parameter int ADDR_W = GLB_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [CONFIG_SIZE-1:0] cfg,
  input  logic [ADDR_W-1:0]      filter_base,
  input  logic [ADDR_W-1:0]      ifmap_base,
  input  logic [ADDR_W-1:0]      ipsum_base,
  input  logic [ADDR_W-1:0]      opsum_base,
  output logic                   busy,
  output logic                   done,
  pe_tile_ctrl_if.master         bus
);
  phase_e                 state_q;
  logic [CONFIG_SIZE-1:0] cfg_q;
  logic [ADDR_W-1:0]      fbase_q, ibase_q, pbase_q, obase_q;
  logic [5:0]             col_q;
  logic [5:0]             ifp_q;
  logic [4:0]             iss_q;
  logic [4:0]             xfr_q;
  logic                   busy_q, done_q, pe_en_q;

  tile_counts_t           cnt;
  logic [4:0]             phase_n;
  logic [8:0]             row_off;
  logic                   rd_phase, rd_avail, rd_req, rd_xfer, hold_valid, cur_ready;
  logic                   ops_fire, phase_last, last_col;
  logic [DATA_BITS-1:0]   hold_data;
  logic [ADDR_W-1:0]      rd_addr_d, wr_addr_d;
  phase_e                 rd_next_d;

  assign cnt = derive_counts(cfg_q[CFG_DW_BIT], cfg_q[CFG_RS_LSB +: 2],
                             cfg_q[CFG_P_LSB +: 2], cfg_q[CFG_Q_LSB +: 2]);

  always_comb begin
    phase_n = 5'd0;
    case (state_q)
      ST_FILT:         phase_n = cnt.nf;
      ST_IFM:          phase_n = (col_q == 6'd0) ? {2'b0, cnt.rs} : 5'd1;
      ST_IPS, ST_OPS:  phase_n = {2'b0, cnt.np};
      default:         phase_n = 5'd0;
    endcase
  end

  assign rd_phase   = (state_q == ST_FILT) || (state_q == ST_IFM) || (state_q == ST_IPS);
  assign rd_avail   = rd_phase && (iss_q < phase_n);
  assign row_off    = {3'b0, col_q} * {6'b0, cnt.np};
  assign phase_last = (xfr_q == phase_n - 5'd1);
  assign last_col   = (col_q == {1'b0, cfg_q[CFG_F_LSB +: 5]});
  assign ops_fire   = (state_q == ST_OPS) && bus.opsum_valid;

  always_comb begin
    cur_ready = 1'b0;
    rd_addr_d = '0;
    rd_next_d = ST_OPS;
    case (state_q)
      ST_FILT: begin
        cur_ready = bus.filter_ready;
        rd_addr_d = fbase_q + ADDR_W'(iss_q);
        rd_next_d = ST_IFM;
      end
      ST_IFM: begin
        cur_ready = bus.ifmap_ready;
        rd_addr_d = ibase_q + ADDR_W'(ifp_q);
        rd_next_d = ST_IPS;
      end
      ST_IPS: begin
        cur_ready = bus.ipsum_ready;
        rd_addr_d = pbase_q + ADDR_W'(row_off) + ADDR_W'(iss_q);
        rd_next_d = ST_OPS;
      end
      default: ;
    endcase
  end

  assign wr_addr_d = obase_q + ADDR_W'(row_off) + ADDR_W'(xfr_q);

  pe_rd_stream u_rd_stream (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_avail_i (rd_avail),
    .ready_i    (cur_ready),
    .rdata_i    (bus.glb_rdata),
    .rd_req_o   (rd_req),
    .data_o     (hold_data),
    .valid_o    (hold_valid),
    .xfer_o     (rd_xfer)
  );

  assign bus.glb_en       = rd_req || ops_fire;
  assign bus.glb_we       = ops_fire;
  assign bus.glb_addr     = ops_fire ? wr_addr_d : (rd_req ? rd_addr_d : '0);
  assign bus.glb_wdata    = ops_fire ? bus.opsum : '0;
  assign bus.PE_en        = pe_en_q;
  assign bus.i_config     = cfg_q;
  assign bus.filter       = (state_q == ST_FILT) ? hold_data : '0;
  assign bus.ifmap        = (state_q == ST_IFM)  ? hold_data : '0;
  assign bus.ipsum        = (state_q == ST_IPS)  ? hold_data : '0;
  assign bus.filter_valid = (state_q == ST_FILT) && hold_valid;
  assign bus.ifmap_valid  = (state_q == ST_IFM)  && hold_valid;
  assign bus.ipsum_valid  = (state_q == ST_IPS)  && hold_valid;
  assign bus.opsum_ready  = (state_q == ST_OPS);
  assign busy             = busy_q;
  assign done             = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cfg_q   <= '0;
      fbase_q <= '0;
      ibase_q <= '0;
      pbase_q <= '0;
      obase_q <= '0;
      col_q   <= '0;
      ifp_q   <= '0;
      iss_q   <= '0;
      xfr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pe_en_q <= 1'b0;
    end else begin
      pe_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cfg_q   <= cfg;
            fbase_q <= filter_base;
            ibase_q <= ifmap_base;
            pbase_q <= ipsum_base;
            obase_q <= opsum_base;
            col_q   <= '0;
            ifp_q   <= '0;
            iss_q   <= '0;
            xfr_q   <= '0;
            busy_q  <= 1'b1;
            pe_en_q <= 1'b1;
            state_q <= ST_CFG;
          end
        end
        ST_CFG: state_q <= ST_FILT;
        ST_FILT, ST_IFM, ST_IPS: begin
          if (rd_req) begin
            iss_q <= iss_q + 5'd1;
            if (state_q == ST_IFM) ifp_q <= ifp_q + 6'd1;
          end
          // issue and transfer never coincide, so clearing iss_q here cannot lose a read
          if (rd_xfer) begin
            if (phase_last) begin
              iss_q   <= '0;
              xfr_q   <= '0;
              state_q <= rd_next_d;
            end else begin
              xfr_q <= xfr_q + 5'd1;
            end
          end
        end
        ST_OPS: begin
          if (ops_fire) begin
            if (phase_last) begin
              xfr_q <= '0;
              if (last_col) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= ST_DONE;
              end else begin
                col_q   <= col_q + 6'd1;
                state_q <= ST_IFM;
              end
            end else begin
              xfr_q <= xfr_q + 5'd1;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_tile_ctrl.sv
// tb/tb_pe_tile_ctrl.sv - scoreboard bench for pe_tile_ctrl with a GLB model and a PE opsum driver
module tb_pe_tile_ctrl;
  import pe_tile_ctrl_pkg::*;

  localparam logic [31:0] OPS_TAG = 32'hF00D_0000;
  localparam logic [CONFIG_SIZE-1:0] CFG1 = {1'b0, 2'd2, 1'b0, 2'd1, 5'd1, 2'd1};
  localparam logic [CONFIG_SIZE-1:0] CFG2 = {1'b1, 2'd2, 1'b0, 2'd0, 5'd0, 2'd2};

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   start;
  logic [CONFIG_SIZE-1:0] cfg;
  logic [15:0]            filter_base, ifmap_base, ipsum_base, opsum_base;
  logic                   busy, done;

  pe_tile_ctrl_if bus ();

  pe_tile_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cfg         (cfg),
    .filter_base (filter_base),
    .ifmap_base  (ifmap_base),
    .ipsum_base  (ipsum_base),
    .opsum_base  (opsum_base),
    .busy        (busy),
    .done        (done),
    .bus         (bus)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int filt_seen = 0, ifm_seen = 0, ips_seen = 0, wr_seen = 0;
  int pe_en_cnt = 0, done_cnt = 0, glb_reads = 0;
  int stall_cfg = 0;
  logic noisy = 1'b0;

  logic [15:0] exp_raddr[$];
  logic [31:0] exp_filt[$];
  logic [31:0] exp_ifm[$];
  logic [31:0] exp_ips[$];
  logic [47:0] exp_wr[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [15:0] a);
    return {~a, a};
  endfunction

  always @(posedge clk) begin
    if (bus.glb_en && !bus.glb_we) bus.glb_rdata <= mem_val(bus.glb_addr);
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (bus.PE_en) pe_en_cnt++;
      if (done) begin
        done_cnt++;
        check("busy_low_at_done", 64'(busy), 64'd0);
      end
      if (bus.filter_valid || bus.ifmap_valid || bus.ipsum_valid)
        check("one_valid", 64'($countones({bus.filter_valid, bus.ifmap_valid, bus.ipsum_valid}) > 1), 64'd0);
      if (bus.glb_en && !bus.glb_we) begin
        glb_reads++;
        if (exp_raddr.size() == 0) check("rd_unexpected", 64'd1, 64'd0);
        else check("rd_addr", 64'(bus.glb_addr), 64'(exp_raddr.pop_front()));
      end
      if (bus.glb_en && bus.glb_we) begin
        wr_seen++;
        check("we_needs_valid", 64'(bus.opsum_valid && bus.opsum_ready), 64'd1);
        if (exp_wr.size() == 0) check("wr_unexpected", 64'd1, 64'd0);
        else check("wr_addr_data", 64'({bus.glb_addr, bus.glb_wdata}), 64'(exp_wr.pop_front()));
      end
      if (bus.filter_valid && bus.filter_ready) begin
        filt_seen++;
        if (exp_filt.size() == 0) check("filt_unexpected", 64'd1, 64'd0);
        else check("filter_data", 64'(bus.filter), 64'(exp_filt.pop_front()));
      end
      if (bus.ifmap_valid && bus.ifmap_ready) begin
        ifm_seen++;
        if (exp_ifm.size() == 0) check("ifm_unexpected", 64'd1, 64'd0);
        else check("ifmap_data", 64'(bus.ifmap), 64'(exp_ifm.pop_front()));
      end
      if (bus.ipsum_valid && bus.ipsum_ready) begin
        ips_seen++;
        if (exp_ips.size() == 0) check("ips_unexpected", 64'd1, 64'd0);
        else check("ipsum_data", 64'(bus.ipsum), 64'(exp_ips.pop_front()));
      end
    end
  end

  initial begin : pe_opsum
    int   ops_cnt;
    int   stall_left;
    logic rdy_seen;
    ops_cnt = 0;
    stall_left = 0;
    rdy_seen = 1'b0;
    bus.opsum_valid = 1'b0;
    bus.opsum = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.opsum_valid && rdy_seen) ops_cnt++;
      if (bus.PE_en) begin
        ops_cnt = 0;
        stall_left = stall_cfg;
      end
      rdy_seen = bus.opsum_ready;
      if (bus.opsum_ready) begin
        if (stall_left > 0) begin
          stall_left--;
          bus.opsum_valid = 1'b0;
        end else begin
          bus.opsum_valid = 1'b1;
          bus.opsum = OPS_TAG + 32'(ops_cnt);
        end
      end else begin
        bus.opsum_valid = noisy;
        bus.opsum = 32'hDEAD_0000 | 32'(ops_cnt);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rd(input int kind, input logic [15:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      logic [15:0] a;
      a = base + 16'(k);
      exp_raddr.push_back(a);
      if (kind == 0) exp_filt.push_back(mem_val(a));
      else if (kind == 1) exp_ifm.push_back(mem_val(a));
      else exp_ips.push_back(mem_val(a));
    end
  endtask

  task automatic push_wr(input logic [15:0] base, input int tag0, input int n);
    for (int k = 0; k < n; k++) exp_wr.push_back({base + 16'(k), OPS_TAG + 32'(tag0 + k)});
  endtask

  // p=2 q=2 rs=3 F=1: 6 filter, col0 3 ifmap/2 ipsum/2 opsum, col1 1 ifmap/2 ipsum/2 opsum
  task automatic push_tile1(input logic [15:0] fb, input logic [15:0] ib,
                            input logic [15:0] pb, input logic [15:0] ob);
    push_rd(0, fb, 6);
    push_rd(1, ib, 3);
    push_rd(2, pb, 2);
    push_wr(ob, 0, 2);
    push_rd(1, ib + 16'd3, 1);
    push_rd(2, pb + 16'd2, 2);
    push_wr(ob + 16'd2, 2, 2);
  endtask

  task automatic launch(input logic [CONFIG_SIZE-1:0] c, input logic [15:0] fb, input logic [15:0] ib,
                        input logic [15:0] pb, input logic [15:0] ob);
    cfg = c;
    filter_base = fb;
    ifmap_base = ib;
    ipsum_base = pb;
    opsum_base = ob;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < bound) begin
      tick();
      n++;
    end
    check({name, "_done_seen"}, 64'(done_cnt != d0), 64'd1);
  endtask

  task automatic check_empty(input string name);
    check({name, "_rd_left"}, 64'(exp_raddr.size()), 64'd0);
    check({name, "_filt_left"}, 64'(exp_filt.size()), 64'd0);
    check({name, "_ifm_left"}, 64'(exp_ifm.size()), 64'd0);
    check({name, "_ips_left"}, 64'(exp_ips.size()), 64'd0);
    check({name, "_wr_left"}, 64'(exp_wr.size()), 64'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int   p0, d0, f0, i0, s0, w0, r0, n;
    logic [31:0] held;

    rst_n = 1'b0;
    start = 1'b0;
    cfg = '0;
    filter_base = '0;
    ifmap_base = '0;
    ipsum_base = '0;
    opsum_base = '0;
    bus.filter_ready = 1'b1;
    bus.ifmap_ready = 1'b1;
    bus.ipsum_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_glb_en", 64'(bus.glb_en), 64'd0);
    check("rst_pe_en", 64'(bus.PE_en), 64'd0);
    check("rst_i_config", 64'(bus.i_config), 64'd0);
    check("rst_opsum_ready", 64'(bus.opsum_ready), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // tile 1: non-depthwise, with filter backpressure and an ignored start
    noisy = 1'b1;
    stall_cfg = 0;
    push_tile1(16'h0100, 16'h0200, 16'h0300, 16'h0400);
    p0 = pe_en_cnt; d0 = done_cnt; f0 = filt_seen; i0 = ifm_seen; s0 = ips_seen; w0 = wr_seen;
    launch(CFG1, 16'h0100, 16'h0200, 16'h0300, 16'h0400);
    check("t1_busy", 64'(busy), 64'd1);
    n = 0;
    while (filt_seen - f0 < 2 && n < 200) begin tick(); n++; end
    check("t1_two_filt", 64'(filt_seen - f0 >= 2), 64'd1);
    bus.filter_ready = 1'b0;
    n = 0;
    while (!bus.filter_valid && n < 20) begin tick(); n++; end
    check("bp_valid_up", 64'(bus.filter_valid), 64'd1);
    held = bus.filter;
    r0 = glb_reads;
    repeat (5) begin
      @(negedge clk);
      check("bp_valid_held", 64'(bus.filter_valid), 64'd1);
      check("bp_data_held", 64'(bus.filter), 64'(held));
    end
    check("bp_no_reads", 64'(glb_reads - r0), 64'd0);
    tick();
    bus.filter_ready = 1'b1;
    launch(13'h1FFF, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF);
    @(negedge clk);
    check("t1_cfg_kept", 64'(bus.i_config), 64'(CFG1));
    check("t1_busy_kept", 64'(busy), 64'd1);
    wait_done("t1", 2000);
    tick();
    check("t1_pe_en_pulses", 64'(pe_en_cnt - p0), 64'd1);
    check("t1_done_pulses", 64'(done_cnt - d0), 64'd1);
    check("t1_filt_words", 64'(filt_seen - f0), 64'd6);
    check("t1_ifm_words", 64'(ifm_seen - i0), 64'd4);
    check("t1_ips_words", 64'(ips_seen - s0), 64'd4);
    check("t1_wr_words", 64'(wr_seen - w0), 64'd4);
    check("t1_busy_low", 64'(busy), 64'd0);
    check_empty("t1");

    // tile 2: depthwise, filter base wraps, opsum stalled 4 cycles
    noisy = 1'b0;
    stall_cfg = 4;
    push_rd(0, 16'hFFFE, 3);
    push_rd(1, 16'h0500, 3);
    push_rd(2, 16'h0600, 3);
    push_wr(16'h0700, 0, 3);
    d0 = done_cnt; w0 = wr_seen;
    launch(CFG2, 16'hFFFE, 16'h0500, 16'h0600, 16'h0700);
    n = 0;
    while (!bus.opsum_ready && n < 300) begin tick(); n++; end
    check("t2_ops_reached", 64'(bus.opsum_ready), 64'd1);
    repeat (4) begin
      @(negedge clk);
      check("t2_no_write_in_stall", 64'(bus.glb_en), 64'd0);
    end
    wait_done("t2", 500);
    tick();
    check("t2_done_pulses", 64'(done_cnt - d0), 64'd1);
    check("t2_wr_words", 64'(wr_seen - w0), 64'd3);
    check_empty("t2");

    // tile 3: reset during OPS aborts without done
    stall_cfg = 2;
    push_tile1(16'h0100, 16'h0200, 16'h0300, 16'h0400);
    launch(CFG1, 16'h0100, 16'h0200, 16'h0300, 16'h0400);
    n = 0;
    while (!bus.opsum_ready && n < 300) begin tick(); n++; end
    check("t3_ops_reached", 64'(bus.opsum_ready), 64'd1);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("t3_rst_busy", 64'(busy), 64'd0);
    check("t3_rst_glb", 64'({bus.glb_en, bus.glb_we, bus.glb_addr, bus.glb_wdata}), 64'd0);
    check("t3_rst_pe", 64'({bus.PE_en, bus.i_config}), 64'd0);
    check("t3_rst_valids", 64'({bus.filter_valid, bus.ifmap_valid, bus.ipsum_valid, bus.opsum_ready}), 64'd0);
    check("t3_rst_data", 64'(bus.filter | bus.ifmap | bus.ipsum), 64'd0);
    repeat (3) tick();
    check("t3_no_done", 64'(done_cnt - d0), 64'd0);
    rst_n = 1'b1;
    exp_raddr.delete();
    exp_filt.delete();
    exp_ifm.delete();
    exp_ips.delete();
    exp_wr.delete();
    tick();

    // tile 4: full tile after the abort, new bases
    stall_cfg = 0;
    push_tile1(16'h1000, 16'h2000, 16'h3000, 16'h4000);
    p0 = pe_en_cnt; d0 = done_cnt; w0 = wr_seen;
    launch(CFG1, 16'h1000, 16'h2000, 16'h3000, 16'h4000);
    wait_done("t4", 2000);
    tick();
    check("t4_pe_en_pulses", 64'(pe_en_cnt - p0), 64'd1);
    check("t4_done_pulses", 64'(done_cnt - d0), 64'd1);
    check("t4_wr_words", 64'(wr_seen - w0), 64'd4);
    check_empty("t4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_tile_ctrl.md
Name: pe_tile_ctrl

Overview:
Sequencer that drives one PE through a complete tile: latches the tile config, pulses PE_en, and streams filter, ifmap and ipsum words from the global buffer (GLB) into the PE.
It collects opsum words from the PE back into the GLB and tracks output columns until the tile finishes.
It sits between the GLB single-port SRAM and the PE's valid/ready stream ports, one instance per PE in standalone tests, or per PE-set under the array controller.

Parameters:
ADDR_W, 16, GLB word address width
DATA_BITS, 32, GLB/PE stream word width (4 packed 8-bit elements)
CONFIG_SIZE, 13, PE config word width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle tile start request
cfg  in  CONFIG_SIZE  tile config: [12] depthwise, [11:10] rs-1, [9] mode, [8:7] p-1, [6:2] F (columns-1), [1:0] q-1
filter_base, ifmap_base, ipsum_base, opsum_base  in  ADDR_W each  GLB word base addresses
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at tile end
glb_en  out  1  GLB access strobe
glb_we  out  1  GLB write (1) / read (0)
glb_addr  out  ADDR_W  GLB word address
glb_wdata  out  DATA_BITS  GLB write data
glb_rdata  in  DATA_BITS  GLB read data, valid 1 cycle after a read strobe
PE_en  out  1  one-cycle PE start/config-load pulse
i_config  out  CONFIG_SIZE  config to PE (latched cfg)
filter, ifmap, ipsum  out  DATA_BITS each  stream data to PE
filter_valid, ifmap_valid, ipsum_valid  out  1 each  stream valids
filter_ready, ifmap_ready, ipsum_ready  in  1 each  PE readies
opsum  in  DATA_BITS  PE output psum
opsum_valid  in  1  PE opsum valid
opsum_ready  out  1  accept opsum

Behaviour:
- Reset: all outputs 0; state IDLE; counters, holding register and cfg latch cleared. The PE shares the reset. Reset mid-tile aborts without a done pulse.
- Derived counts from latched cfg (p, q, rs = field+1; C = F+1):
  - NF = p*rs filter words.
  - ifmap words: rs for column 0, then 1 per column.
  - NP = depthwise ? q : p ipsum words per column, and the same NP opsum words per column.
  - Widths: NF at most 16 (5 bits); C at most 32 (6 bits).
- States: IDLE, CFG, FILT, IFM, IPS, OPS, DONE.
  - IDLE: start latches cfg and bases, sets busy, goes to CFG. start while busy is ignored.
  - CFG: PE_en=1 for exactly one cycle with i_config=cfg; goes to FILT.
  - FILT: NF words from filter_base+k.
  - IFM: this column's ifmap words from ifmap_base + running ifmap word pointer. The pointer is contiguous across columns; the tile uses rs+F words in total.
  - IPS: NP words from ipsum_base + col*NP + k.
  - OPS: opsum_ready=1. Each cycle with opsum_valid, write opsum to opsum_base + col*NP + k (glb_en=1, glb_we=1, glb_wdata=opsum). After NP writes: if col==F go to DONE, else col+1 and go to IFM.
  - DONE: done=1 for one cycle, busy drops the same cycle, then IDLE.
- Read stream engine (FILT, IFM, IPS):
  - One outstanding read feeds a 1-word holding register.
  - A read is issued when the holding register is empty and words remain in the current phase.
  - glb_rdata is captured the next cycle and the matching *_valid rises.
  - Data and valid are held stable until the PE's ready is sampled high; the transfer completes on valid&&ready.
  - Holding-register empty is set on the transfer cycle; the next read may issue the following cycle.
  - Throughput: at most 1 word per 2 cycles.
  - Only the valid of the current phase may be high.
  - A phase ends on its last transfer; the next phase starts the cycle after.
- GLB port: reads and writes are mutually exclusive by phase; glb_en=0 outside active accesses. Addresses wrap modulo 2^ADDR_W.
- opsum_valid outside OPS is ignored; opsum_ready=0 there.

Decomposition:
- Shared package: phase state enum, cfg field bit positions, CONFIG_SIZE/DATA_BITS constants, and a count-derivation function (NF, NP).
- One natural sub-module: pe_rd_stream, the one-outstanding-read engine plus holding register with valid/ready, instantiated once and muxed by phase.

Test Plan:
- Non-depthwise tile, cfg p=2, q=2, rs=3, F=1:
  - Expect 1 PE_en pulse, 6 filter words, then column 0: 3 ifmap, 2 ipsum, 2 opsum; then column 1: 1 ifmap, 2 ipsum, 2 opsum.
  - Opsum lands at opsum_base+0..3; done pulses once; ifmap addresses are base+0..3.
- Depthwise tile, q=3, p=1, rs=3, F=0: expect 3 filter, 3 ifmap, 3 ipsum, 3 opsum words, then done.
- Backpressure: hold filter_ready=0 for 5 cycles mid-phase. filter_valid and data stay constant, and no extra GLB reads are issued.
- start pulsed during busy -> ignored; cfg change mid-tile does not alter i_config or counts.
- rst_n asserted during OPS -> all outputs 0 immediately; no done; a new start runs a full tile correctly.
- Stalled opsum: PE delays opsum_valid 4 cycles -> no GLB write until valid; write address is the correct col*NP+k.
